// File: rtl/tim_pkg.sv
// Shared types and helpers for the round-robin timer scheduler.
package tim_pkg;

    localparam int TIM_TW_DEF = 4;
    localparam int RR_MAX     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tim_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit searching upward from ptr+1, wrapping modulo n.
    // Iterating from the farthest offset down lets the nearest hit win.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        ptr,
                                         input int                n = RR_MAX);
        rr_pick_t r;
        int       i;
        r = '0;
        i = 0;
        for (int k = RR_MAX; k >= 1; k--) begin
            if (k <= n) begin
                i = (int'(ptr) + k) % n;
                if (req[i[2:0]]) begin
                    r.valid = 1'b1;
                    r.idx   = i[2:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tim_sched_if.sv
// Request/grant bundle between client FSMs and the shared timer scheduler.
interface tim_sched_if #(
    parameter int N_REQ = 4,
    parameter int TW    = 4
);
    logic                en;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*TW-1:0] dur;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    done;
    logic                busy;
    logic [TW-1:0]       tim;

    modport master (output en, req, dur, input gnt, done, busy, tim);
    modport slave  (input en, req, dur, output gnt, done, busy, tim);
endinterface

// File: rtl/tim_cnt.sv
// Loadable down counter with terminal-count flag; load wins over decrement.
module tim_cnt
    import tim_pkg::*;
#(
    parameter int TW = TIM_TW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load,
    input  logic [TW-1:0] din,
    output logic [TW-1:0] cnt,
    output logic          zero
);

    logic [TW-1:0] cnt_q, cnt_d;

    assign zero = (cnt_q == '0);
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = din;
        end else if (en && !zero) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tim_sched.sv
// Round-robin owner of one shared down-counting timer.
//   state | meaning
//   IDLE  | no owner, arbitrate when en=1 and any req is set
//   RUN   | counting the owner's delay
//   DONE  | done[owner] high, held while en=0
module tim_sched
    import tim_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int TW    = TIM_TW_DEF
) (
    input  logic        clk,
    input  logic        rst,
    tim_sched_if.slave  bus
);

    tim_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [2:0]       ptr_q, ptr_d;

    logic [RR_MAX-1:0] req_ext;
    rr_pick_t          pick;
    logic              cnt_load;
    logic              cnt_dec;
    logic [TW-1:0]     cnt_din;
    logic [TW-1:0]     cnt_val;
    logic              cnt_zero;

    tim_cnt #(.TW(TW)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_dec),
        .load (cnt_load),
        .din  (cnt_din),
        .cnt  (cnt_val),
        .zero (cnt_zero)
    );

    always_comb begin
        req_ext              = '0;
        req_ext[N_REQ-1:0]   = bus.req;
        pick                 = rr_pick(req_ext, ptr_q, N_REQ);
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = done_q;
        ptr_d    = ptr_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_din  = '0;
        case (state_q)
            IDLE: begin
                done_d = '0;
                if (bus.en && pick.valid) begin
                    state_d  = RUN;
                    ptr_d    = pick.idx;
                    cnt_load = 1'b1;
                    gnt_d    = '0;
                    for (int k = 0; k < N_REQ; k++) begin
                        if (pick.idx == 3'(k)) begin
                            gnt_d[k] = 1'b1;
                            cnt_din  = bus.dur[k*TW +: TW];
                        end
                    end
                end
            end
            RUN: begin
                // Owner withdrawing its request aborts even while frozen.
                if ((bus.req & gnt_q) == '0) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (bus.en) begin
                    if (cnt_zero) begin
                        state_d = DONE;
                        done_d  = gnt_q;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.en) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    done_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                done_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            ptr_q   <= 3'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.tim  = cnt_val;

endmodule

// File: doc/tim_sched.md
# tim_sched

Round-robin scheduler that shares one loadable down-counting timer among `N_REQ` requesters. Each requester asks for a delay of `dur` ticks. The block grants the timer to one requester at a time, counts the delay while `en` is high, and returns a one-cycle `done` pulse to the owner. It sits between client FSMs needing timed waits and the single timer resource, so no client instantiates its own counter.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `TW`, 4, timer width in bits; max delay `2**TW-1`

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `en`  in  1  global tick enable; 0 freezes the FSM and counter
- `req`  in  `N_REQ`  per-requester request; level, held until `done`
- `dur`  in  `N_REQ*TW`  packed durations; slice i is requester i, sampled at grant only
- `gnt`  out  `N_REQ`  one-hot owner of the timer; 0 when idle
- `done`  out  `N_REQ`  one-cycle completion pulse to the owner
- `busy`  out  1  timer owned (state RUN or DONE)
- `tim`  out  `TW`  remaining count of the current delay

## Operation
- States:
  - IDLE: no owner, `gnt`=0, `busy`=0.
  - RUN: counting, `gnt` holds the owner.
  - DONE: `done[owner]`=1 for exactly this cycle, `gnt` still held.
- IDLE: with `en`=1 and `req`≠0, pick a winner and load the counter.
  - The winner is the first set bit searching upward from `ptr+1`, wrapping modulo `N_REQ`.
  - At the next edge: state RUN, `gnt`=onehot(w), `tim`=`dur[w]`, `ptr`=w.
  - `ptr` resets to `N_REQ-1`, so req0 has the highest priority after reset.
- RUN, `en`=1:
  - `tim`≠0: `tim` decrements.
  - `tim`=0: go to DONE.
  - So `dur`=0 gives one RUN cycle, and `dur`=D gives D+1 RUN cycles.
- DONE: always go to IDLE at the next edge. There is no back-to-back grant; the IDLE cycle is mandatory.
- `en`=0 in any state: state, `tim`, `gnt` and `ptr` hold.
  - A DONE cycle with `en`=0 is stretched, so `done` stays high until the first DONE cycle with `en`=1.
  - Clients count a `done` high level as one completion.
- Abort: owner's `req` low during RUN, regardless of `en`:
  - Next edge: IDLE with `gnt`=0 and no `done`.
  - `ptr` keeps the aborted owner, so the aborted requester gets lowest priority next round.
- Changes on `dur` after grant are ignored. Non-owner `req` changes are ignored until IDLE.
- Width rules: `tim` is unsigned `TW` bits. There is no decrement below 0 because the 0 check precedes the decrement.

## Timing
- Reset: `rst`=1 clears asynchronously to state IDLE, `gnt`=0, `done`=0, `busy`=0, `tim`=0, `ptr`=`N_REQ-1`.
- Reset mid-RUN drops the grant with no `done`.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency with `en` held at 1:
  - `req` first sampled high in IDLE: `gnt` high 1 cycle later.
  - `done` high D+1 cycles after `gnt` rises.
  - IDLE 1 cycle after `done`.
- Minimum period per grant: D+3 cycles (IDLE, D+1 RUN, DONE).

## Structure
- Package `tim_pkg`:
  - state enum `tim_state_t` {IDLE, RUN, DONE}
  - `TIM_TW_DEF`=4
  - function `rr_pick(req, ptr)` returning the winner index and a valid bit
- Sub-module `tim_cnt`: `TW`-bit loadable down counter.
  - Ports: `clk`, `rst`, `en`, `load`, `din`, `cnt`, `zero`.
  - `load` has priority over decrement.
  - `tim_sched` owns the FSM, arbitration pointer and output registers.

## Test plan
All scenarios use `N_REQ`=4 and `TW`=4.
- Reset: `rst`=1 with `req`=1111 → `gnt`=0, `done`=0, `busy`=0, `tim`=0 throughout. After release with `en`=1, the first `gnt`=0001.
- Single request: `req`=0010, `dur[1]`=3, `en`=1 →
  - `gnt`=0010 with `tim`=3,2,1,0 over 4 cycles.
  - Then 1 cycle of `done`=0010.
  - Then `gnt`=0, `busy`=0.
- Fairness: `req`=1111 held, all `dur`=0 →
  - Grant order 0,1,2,3,0, each grant lasting 3 cycles (RUN, DONE, IDLE).
  - Exactly one `done` bit per grant.
- Freeze: `dur[2]`=5, `en` dropped for 6 cycles while `tim`=2 → `tim` holds 2, and `done[2]` arrives 6 cycles later than the nominal 6-cycle latency.
- Abort: `req[0]` dropped while `tim`=4, with `req[3]` pending → next cycle `gnt`=0 and no `done[0]`, then `gnt`=1000.
- Async reset and max delay:
  - `rst` pulsed mid-RUN → outputs 0 before the next edge.
  - After release, `dur[1]`=15 → `done[1]` arrives exactly 16 cycles after `gnt` rises.
